// File: rtl/pingpong_bank_scheduler.sv
// pingpong_bank_scheduler
// Sequencing controller for the two-bank (ping-pong) line buffer of the
// convolution front end. Pixel columns stream into the bank being filled,
// while the other (full) bank is drained as KERNEL_SIZE-wide window reads.
// A per-frame strip counter flags the last drained strip of each frame.
//
// Bank flags, pointers, win_valid, strip_cnt and frame_done are registered.
// Handshake, write strobes and read strobes are combinational from the
// current state and inputs, so they land in the same cycle as the data.

module pingpong_bank_scheduler #(
    parameter int COLUMNS     = 4,
    parameter int KERNEL_SIZE = 3,
    parameter int ADDR_SIZE   = 4,
    parameter int STRIPS      = 14
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        out_ready,
    output logic                        write_enable_1,
    output logic                        write_enable_2,
    output logic                        read_enable_1,
    output logic                        read_enable_2,
    output logic [ADDR_SIZE-1:0]        wr_addr,
    output logic [ADDR_SIZE-1:0]        rd_addr,
    output logic                        win_valid,
    output logic                        wr_bank,
    output logic                        rd_bank,
    output logic [$clog2(STRIPS+1)-1:0] strip_cnt,
    output logic                        frame_done
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int WINDOWS = COLUMNS - KERNEL_SIZE + 1;
    localparam int CNT_W   = $clog2(STRIPS + 1);

    localparam logic [ADDR_SIZE-1:0] LAST_COL   = ADDR_SIZE'(COLUMNS - 1);
    localparam logic [ADDR_SIZE-1:0] LAST_WIN   = ADDR_SIZE'(WINDOWS - 1);
    localparam logic [CNT_W-1:0]     LAST_STRIP = CNT_W'(STRIPS - 1);

    // Elaboration-time sanity checks on the parameter set.
    if (WINDOWS < 1 || WINDOWS > COLUMNS) begin : g_bad_kernel
        $error("pingpong_bank_scheduler: KERNEL_SIZE must be in 1..COLUMNS");
    end
    if ((2 ** ADDR_SIZE) < COLUMNS) begin : g_bad_addr
        $error("pingpong_bank_scheduler: ADDR_SIZE too narrow for COLUMNS");
    end
    if (STRIPS < 1) begin : g_bad_strips
        $error("pingpong_bank_scheduler: STRIPS must be at least 1");
    end

    // Per-bank occupancy: a bank is either being filled or holding a full
    // strip that is being drained.
    typedef enum logic {
        BANK_FILLING = 1'b0,
        BANK_FULL    = 1'b1
    } bank_state_e;

    // ------------------------------------------------------------------
    // State and next-state signals
    // ------------------------------------------------------------------
    bank_state_e            bank_q [2];
    bank_state_e            bank_d [2];

    logic                   wr_bank_d;
    logic                   rd_bank_d;
    logic [ADDR_SIZE-1:0]   wr_addr_d;
    logic [ADDR_SIZE-1:0]   rd_addr_d;
    logic [CNT_W-1:0]       strip_cnt_d;
    logic                   win_valid_d;
    logic                   frame_done_d;

    // Handshake / strobe terms
    logic                   accept;
    logic                   rd_go;
    logic                   fill_done;
    logic                   drain_done;

    // ------------------------------------------------------------------
    // Handshake and buffer strobes (same-cycle, combinational)
    // ------------------------------------------------------------------
    // Write side accepts while the write bank is not full; read side fires
    // while the read bank is full and downstream is ready. The two can never
    // target the same bank: a full bank blocks writes, an unfilled one reads.
    always_comb begin
        in_ready       = reset && (bank_q[wr_bank] == BANK_FILLING);
        accept         = in_valid && in_ready;
        rd_go          = (bank_q[rd_bank] == BANK_FULL) && out_ready;

        write_enable_1 = accept && !wr_bank;
        write_enable_2 = accept &&  wr_bank;
        read_enable_1  = rd_go  && !rd_bank;
        read_enable_2  = rd_go  &&  rd_bank;
    end

    // ------------------------------------------------------------------
    // Next-state: pointer advance, bank hand-over, strip counting, flush
    // ------------------------------------------------------------------
    // Fill completion and drain completion touch different banks, so both
    // flag updates may land on the same edge without conflict.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block leaves one unassigned and no latch is inferred.
        bank_d       = bank_q;
        wr_bank_d    = wr_bank;
        rd_bank_d    = rd_bank;
        wr_addr_d    = wr_addr;
        rd_addr_d    = rd_addr;
        strip_cnt_d  = strip_cnt;
        win_valid_d  = rd_go;
        frame_done_d = 1'b0;

        fill_done    = accept && (wr_addr == LAST_COL);
        drain_done   = rd_go  && (rd_addr == LAST_WIN);

        // Write pointer: last column closes the bank and hands over.
        if (accept) begin
            if (fill_done) begin
                wr_addr_d         = '0;
                bank_d[wr_bank]   = BANK_FULL;
                wr_bank_d         = !wr_bank;
            end else begin
                wr_addr_d         = wr_addr + 1'b1;
            end
        end

        // Read pointer: last window frees the bank and counts a strip.
        if (rd_go) begin
            if (drain_done) begin
                rd_addr_d         = '0;
                bank_d[rd_bank]   = BANK_FILLING;
                rd_bank_d         = !rd_bank;
                if (strip_cnt == LAST_STRIP) begin
                    // Frame boundary: wrap so STRIPS itself is never shown.
                    strip_cnt_d  = '0;
                    frame_done_d = 1'b1;
                end else begin
                    strip_cnt_d  = strip_cnt + 1'b1;
                end
            end else begin
                rd_addr_d         = rd_addr + 1'b1;
            end
        end

        // Synchronous flush mirrors reset; an in-flight window is dropped.
        if (flush) begin
            bank_d[0]    = BANK_FILLING;
            bank_d[1]    = BANK_FILLING;
            wr_bank_d    = 1'b0;
            rd_bank_d    = 1'b0;
            wr_addr_d    = '0;
            rd_addr_d    = '0;
            strip_cnt_d  = '0;
            win_valid_d  = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State register with asynchronous active-low reset
    // ------------------------------------------------------------------
    // Buffer contents live outside this block and are never cleared here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_q[0]  <= BANK_FILLING;
            bank_q[1]  <= BANK_FILLING;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            strip_cnt  <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            bank_q     <= bank_d;
            wr_bank    <= wr_bank_d;
            rd_bank    <= rd_bank_d;
            wr_addr    <= wr_addr_d;
            rd_addr    <= rd_addr_d;
            strip_cnt  <= strip_cnt_d;
            win_valid  <= win_valid_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_pingpong_bank_scheduler.sv
// tb_pingpong_bank_scheduler
// Scoreboard bench for pingpong_bank_scheduler. The reference model counts
// columns accepted and windows read since the last reset/flush and derives
// bank occupancy, pointers and strip count from those totals. Expected write
// strobes, read strobes and window-valid cycles are queued when stimulus is
// issued; a separate monitor pops and compares what the DUT presents.

module tb_pingpong_bank_scheduler;

    localparam int COLUMNS     = 4;
    localparam int KERNEL_SIZE = 3;
    localparam int ADDR_SIZE   = 4;
    localparam int STRIPS      = 2;
    localparam int WINDOWS     = COLUMNS - KERNEL_SIZE + 1;
    localparam int CNT_W       = $clog2(STRIPS + 1);

    logic                 clk       = 1'b0;
    logic                 reset     = 1'b1;
    logic                 flush     = 1'b0;
    logic                 in_valid  = 1'b0;
    logic                 out_ready = 1'b0;
    logic                 in_ready;
    logic                 write_enable_1;
    logic                 write_enable_2;
    logic                 read_enable_1;
    logic                 read_enable_2;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 win_valid;
    logic                 wr_bank;
    logic                 rd_bank;
    logic [CNT_W-1:0]     strip_cnt;
    logic                 frame_done;

    pingpong_bank_scheduler #(
        .COLUMNS     (COLUMNS),
        .KERNEL_SIZE (KERNEL_SIZE),
        .ADDR_SIZE   (ADDR_SIZE),
        .STRIPS      (STRIPS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_ready      (out_ready),
        .write_enable_1 (write_enable_1),
        .write_enable_2 (write_enable_2),
        .read_enable_1  (read_enable_1),
        .read_enable_2  (read_enable_2),
        .wr_addr        (wr_addr),
        .rd_addr        (rd_addr),
        .win_valid      (win_valid),
        .wr_bank        (wr_bank),
        .rd_bank        (rd_bank),
        .strip_cnt      (strip_cnt),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct packed {
        logic                 bank;
        logic [ADDR_SIZE-1:0] addr;
    } acc_t;

    acc_t wr_q[$];
    acc_t rd_q[$];
    int   win_q[$];

    // Reference model state: totals since the last reset/flush.
    int cols   = 0;
    int wins   = 0;
    bit fd_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at cycle %0d", name, act, exp, cyc);
    endtask

    // Predict this cycle's behaviour from the totals, queue expected strobes,
    // then advance the totals to what the coming edge should produce.
    task automatic model_cycle();
        int   fills;
        int   drains;
        bit   acc;
        bit   go;
        acc_t e;
        if (!reset) begin
            cols   = 0;
            wins   = 0;
            fd_exp = 1'b0;
            win_q.delete();
        end
        fills  = cols / COLUMNS;
        drains = wins / WINDOWS;
        check("in_ready",   in_ready,   32'(reset && (fills - drains < 2)));
        check("wr_bank",    wr_bank,    32'(fills % 2));
        check("rd_bank",    rd_bank,    32'(drains % 2));
        check("strip_cnt",  strip_cnt,  32'(drains % STRIPS));
        check("frame_done", frame_done, 32'(fd_exp));

        acc = reset && in_valid  && (fills - drains < 2);
        go  = reset && out_ready && (fills - drains >= 1);
        if (acc) begin
            e.bank = (fills % 2) == 1;
            e.addr = ADDR_SIZE'(cols % COLUMNS);
            wr_q.push_back(e);
        end
        if (go) begin
            e.bank = (drains % 2) == 1;
            e.addr = ADDR_SIZE'(wins % WINDOWS);
            rd_q.push_back(e);
            if (!flush) win_q.push_back(cyc + 1);
        end

        fd_exp = 1'b0;
        if (flush || !reset) begin
            cols = 0;
            wins = 0;
        end else begin
            if (acc) cols++;
            if (go) begin
                wins++;
                if ((wins % WINDOWS == 0) && ((wins / WINDOWS) % STRIPS == 0)) fd_exp = 1'b1;
            end
        end
    endtask

    // One clock cycle of stimulus: drive at the falling edge, model at +1.
    task automatic step(input bit rs, input bit v, input bit r, input bit f);
        @(negedge clk);
        reset     = rs;
        in_valid  = v;
        out_ready = r;
        flush     = f;
        cyc++;
        #1;
        model_cycle();
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        cyc = -1;
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops expectations whenever the DUT presents strobes/windows
    // ------------------------------------------------------------------
    initial begin : monitor
        acc_t e;
        bit   exp_win;
        forever begin
            @(negedge clk);
            #2;
            check("write_strobe", 32'(write_enable_1 | write_enable_2), 32'(wr_q.size() > 0));
            check("write_onehot", 32'(write_enable_1 & write_enable_2), 32'd0);
            if (wr_q.size() > 0) begin
                e = wr_q.pop_front();
                if (write_enable_1 | write_enable_2) begin
                    check("write_bank", write_enable_2, e.bank);
                    check("wr_addr",    wr_addr,        e.addr);
                end
            end
            check("read_strobe", 32'(read_enable_1 | read_enable_2), 32'(rd_q.size() > 0));
            check("read_onehot", 32'(read_enable_1 & read_enable_2), 32'd0);
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                if (read_enable_1 | read_enable_2) begin
                    check("read_bank", read_enable_2, e.bank);
                    check("rd_addr",   rd_addr,       e.addr);
                end
            end
            exp_win = (win_q.size() > 0) && (win_q[0] == cyc);
            check("win_valid", win_valid, exp_win);
            while (win_q.size() > 0 && win_q[0] <= cyc) void'(win_q.pop_front());
        end
    end

    // ------------------------------------------------------------------
    // Directed phases
    // ------------------------------------------------------------------
    task automatic phase_basic();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            if (c == 0) check("tp_we1_c0", write_enable_1, 1'b1);
            if (c == 4) begin
                check("tp_re1_c4",    read_enable_1, 1'b1);
                check("tp_rdaddr_c4", rd_addr,       0);
                check("tp_we2_c4",    write_enable_2, 1'b1);
            end
            if (c == 5) begin
                check("tp_re1_c5",    read_enable_1, 1'b1);
                check("tp_rdaddr_c5", rd_addr,       1);
                check("tp_wv_c5",     win_valid,     1'b1);
            end
            if (c == 6) check("tp_wv_c6", win_valid, 1'b1);
            if (c == 7) check("tp_wv_c7", win_valid, 1'b0);
        end
    endtask

    task automatic phase_stall();
        do_reset();
        for (int c = 0; c < 26; c++) begin
            step(1'b1, 1'b1, c >= 20, 1'b0);
            if (c == 8)  check("tp_stall_ready_c8",  in_ready, 1'b0);
            if (c == 21) check("tp_stall_ready_c21", in_ready, 1'b0);
            if (c == 22) begin
                check("tp_stall_ready_c22", in_ready, 1'b1);
                check("tp_stall_wrbank_c22", wr_bank, 1'b0);
            end
        end
    endtask

    task automatic phase_simultaneous();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 1'b1, c >= 6, 1'b0);
            if (c == 8) begin
                check("tp_sim_ready",  in_ready,      1'b1);
                check("tp_sim_wrbank", wr_bank,       1'b0);
                check("tp_sim_rdbank", rd_bank,       1'b1);
                check("tp_sim_re2",    read_enable_2, 1'b1);
            end
        end
    endtask

    task automatic phase_strips();
        do_reset();
        for (int c = 0; c < 13; c++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            if (c == 5)  check("tp_strip_c5",  strip_cnt, 0);
            if (c == 6)  check("tp_strip_c6",  strip_cnt, 1);
            if (c == 9)  check("tp_fd_c9",     frame_done, 1'b0);
            if (c == 10) begin
                check("tp_strip_c10", strip_cnt,  0);
                check("tp_fd_c10",    frame_done, 1'b1);
            end
            if (c == 11) check("tp_fd_c11", frame_done, 1'b0);
        end
    endtask

    task automatic phase_flush();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b1, 1'b1, c == 5);
            if (c == 5) begin
                check("tp_fl_re1_c5",    read_enable_1, 1'b1);
                check("tp_fl_rdaddr_c5", rd_addr,       1);
            end
            if (c == 6) begin
                check("tp_fl_wraddr", wr_addr,   0);
                check("tp_fl_rdaddr", rd_addr,   0);
                check("tp_fl_strip",  strip_cnt, 0);
                check("tp_fl_wv",     win_valid, 1'b0);
                check("tp_fl_ready",  in_ready,  1'b1);
                check("tp_fl_wrbank", wr_bank,   1'b0);
                check("tp_fl_rdbank", rd_bank,   1'b0);
            end
        end
    endtask

    task automatic phase_async_reset();
        do_reset();
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 1'b1, 1'b0);
        check("tp_ar_wraddr_before", wr_addr, 2);
        #2;
        reset = 1'b0;
        #1;
        check("tp_ar_ready",  in_ready,       1'b0);
        check("tp_ar_we1",    write_enable_1, 1'b0);
        check("tp_ar_wraddr", wr_addr,        0);
        check("tp_ar_wrbank", wr_bank,        1'b0);
        check("tp_ar_rdaddr", rd_addr,        0);
        check("tp_ar_wv",     win_valid,      1'b0);
        check("tp_ar_strip",  strip_cnt,      0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Random traffic with occasional flushes and resets; r_pct biases how
    // often downstream is ready so both-banks-full stalls are exercised.
    task automatic rand_run(input int n, input int r_pct);
        bit v;
        bit r;
        bit f;
        bit rs;
        do_reset();
        for (int i = 0; i < n; i++) begin
            v  = $urandom_range(0, 99) < 75;
            r  = $urandom_range(0, 99) < r_pct;
            f  = $urandom_range(0, 59) == 0;
            rs = $urandom_range(0, 149) != 0;
            step(rs, v, r, f);
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : stimulus
        #1 reset = 1'b0;
        phase_basic();
        phase_stall();
        phase_simultaneous();
        phase_strips();
        phase_flush();
        phase_async_reset();
        rand_run(800, 70);
        rand_run(800, 25);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        check("wr_q_drained",  wr_q.size(),  0);
        check("rd_q_drained",  rd_q.size(),  0);
        check("win_q_drained", win_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pingpong_bank_scheduler.md
# pingpong_bank_scheduler

Sequencing controller for the two-bank line buffer of the convolution front end. It accepts one pixel column per handshake, steers each column into the bank being filled, and drains the full bank as 3×3 window reads while the other bank fills. It also counts drained strips per frame. It sits between the pixel streamer and the ping-pong buffer and drives the buffer's write/read enables and addresses.

## Interface
- COLUMNS, 4: columns per bank (one strip width)
- KERNEL_SIZE, 3: window width. WINDOWS = COLUMNS-KERNEL_SIZE+1 reads per bank.
- ADDR_SIZE, 4: address width. Must satisfy 2^ADDR_SIZE ≥ COLUMNS.
- STRIPS, 14: strips per frame (IMAGE_SIZE-KERNEL_SIZE+1)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear, same effect as reset on the next edge
- in_valid  in  1  upstream column present
- in_ready  out  1  scheduler accepts a column this cycle
- out_ready  in  1  downstream can take a window one cycle later
- write_enable_1, write_enable_2  out  1  bank write strobes
- read_enable_1, read_enable_2  out  1  bank read strobes
- wr_addr  out  ADDR_SIZE  column address in the write bank
- rd_addr  out  ADDR_SIZE  window start column in the read bank
- win_valid  out  1  buffer window outputs valid this cycle
- wr_bank, rd_bank  out  1  0 = bank 1, 1 = bank 2
- strip_cnt  out  $clog2(STRIPS+1)  strips drained in the current frame
- frame_done  out  1  one-cycle pulse on the last strip of a frame

## Operation
- State per bank: a full flag (0 = EMPTY/FILLING, 1 = FULL/DRAINING). Pointers: wr_bank, rd_bank, wr_addr, rd_addr.
- Write side:
  - in_ready = reset & !full[wr_bank].
  - accept = in_valid & in_ready.
  - write_enable_1 = accept & (wr_bank==0); write_enable_2 = accept & (wr_bank==1). Both are combinational, in the same cycle as the data.
  - On accept: wr_addr increments. When wr_addr==COLUMNS-1: wr_addr←0, full[wr_bank]←1, wr_bank toggles.
- Read side:
  - rd_go = full[rd_bank] & out_ready.
  - read_enable_1 = rd_go & (rd_bank==0); read_enable_2 = rd_go & (rd_bank==1). Both combinational.
  - On rd_go: rd_addr increments. When rd_addr==WINDOWS-1: rd_addr←0, full[rd_bank]←0, rd_bank toggles, strip_cnt increments.
- win_valid = rd_go registered one cycle, matching the buffer's registered read.
- Strip count: when strip_cnt reaches STRIPS, frame_done pulses in the same cycle the increment lands and strip_cnt wraps to 0. strip_cnt never shows STRIPS.
- Simultaneous events:
  - Fill completion on one bank and drain completion on the other in the same cycle: both flags update, no conflict.
  - Write and read of the same bank in the same cycle is impossible by construction. The full flag gates writes; reads require full.
- Both banks full: in_ready=0 until the read bank drains. The toggle and flag clear land on the same edge, so in_ready rises the next cycle.
- flush or reset mid-operation: all pointers, flags, strip_cnt and win_valid go to 0. Any in-flight window is dropped. Data in the buffer is not cleared by this block.

## Timing
- Reset values:
  - in_ready=0 while reset is low, 1 after reset is released.
  - All enables, win_valid and frame_done = 0.
  - wr_addr, rd_addr, wr_bank, rd_bank and strip_cnt = 0.
- First window:
  - The first accept happens at cycle 0. The last column is accepted at cycle COLUMNS-1, and full rises at that edge.
  - read_enable is earliest at cycle COLUMNS; win_valid is earliest at cycle COLUMNS+1.
- Window read latency: read_enable → win_valid is exactly 1 cycle. out_ready is sampled only through rd_go; there is no skid buffer.
- Throughput: one column per cycle while a bank is free.
  - A bank drains in WINDOWS cycles, so with WINDOWS ≤ COLUMNS writes never stall at steady state.
- frame_done pulses once, on the edge of the STRIPS-th drain completion.

## Test plan
- Reset release, in_valid held high, out_ready=1, defaults:
  - write_enable_1 is high for cycles 0-3 and write_enable_2 for cycles 4-7.
  - read_enable_1 is high at cycles 4-5 with rd_addr 0,1; win_valid is high at cycles 5-6.
- out_ready=0 with a continuous stream:
  - After 8 accepts, in_ready=0 and both full flags are set.
  - Raise out_ready at cycle 20: in_ready returns at cycle 22, and wr_bank=0.
- Simultaneous completion: time the bank-2 fill to complete on the same edge as the bank-1 drain. After that edge, full=2'b10, wr_bank=0, rd_bank=1.
- STRIPS=2, continuous stream:
  - frame_done pulses on the second drain completion.
  - strip_cnt sequence is 0,1,0.
- Assert flush during the second read of a bank. On the next cycle, all counters, flags and win_valid are 0, and in_ready=1.
- Assert async reset mid-fill, between edges. Outputs go to their reset values immediately, without waiting for a clock edge.
